// File: rtl/jtframe_cpurom_resp_pkg.sv
// Shared types for the CPU ROM responder: FSM state encoding and byte-lane select.
package jtframe_cpurom_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Little-endian lane pick: sel 0 is bits [7:0], sel 3 is bits [31:24].
    function automatic logic [7:0] byte_sel(input logic [31:0] data, input logic [1:0] sel);
        logic [7:0] r;
        case (sel)
            2'd0:    r = data[7:0];
            2'd1:    r = data[15:8];
            2'd2:    r = data[23:16];
            default: r = data[31:24];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jtframe_cpurom_line.sv
// One cache entry: valid/tag/data registers with flush, write and tag compare.
module jtframe_cpurom_line
    import jtframe_cpurom_resp_pkg::*;
#(
    parameter int TW = 15
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          we,
    input  logic          wvalid,
    input  logic [TW-1:0] wtag,
    input  logic [31:0]   wdata,
    input  logic [TW-1:0] lookup,
    output logic          hit,
    output logic [31:0]   data
);

    logic          r_valid;
    logic [TW-1:0] r_tag;
    logic [31:0]   r_data;

    // Tag and data are written even when the fill lands invalid; flush always wins on valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (we)
                r_valid <= wvalid;
            if (we) begin
                r_tag  <= wtag;
                r_data <= wdata;
            end
        end
    end

    assign hit  = r_valid && (r_tag == lookup);
    assign data = r_data;

endmodule

// File: rtl/jtframe_cpurom_resp.sv
// CPU ROM fetch responder: two-line 32-bit cache in front of one SDRAM req/ack slot.
// Handshake: sdram_req stays high until a one-cycle sdram_ack; data_rdy then pulses once with the word.
module jtframe_cpurom_resp
    import jtframe_cpurom_resp_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] cpu_addr,
    input  logic          rom_cs,
    output logic          rom_ok,
    output logic [7:0]    rom_dout,
    input  logic          flush,
    output logic [AW-3:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [31:0]   sdram_din,
    output logic [1:0]    dbg_state
);

    localparam int TW = AW - 2;

    state_t        r_state;
    logic          r_victim;
    logic          r_fill_flushed;
    logic          r_ok;
    logic          r_req;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_dout;
    logic [TW-1:0] r_sdram_addr;

    logic [TW-1:0] w_tag;
    logic [1:0]    w_hit_line;
    logic [31:0]   w_data0;
    logic [31:0]   w_data1;
    logic          w_hit;
    logic          w_fill;
    logic          w_fill_valid;
    logic [7:0]    w_byte;

    assign w_tag        = cpu_addr[AW-1:2];
    assign w_fill       = (r_state == ST_WAIT) && data_rdy;
    assign w_fill_valid = ~(flush | r_fill_flushed);

    jtframe_cpurom_line #(.TW(TW)) u_line0 (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (flush),
        .we     (w_fill && !r_victim),
        .wvalid (w_fill_valid),
        .wtag   (r_sdram_addr),
        .wdata  (sdram_din),
        .lookup (w_tag),
        .hit    (w_hit_line[0]),
        .data   (w_data0)
    );

    jtframe_cpurom_line #(.TW(TW)) u_line1 (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (flush),
        .we     (w_fill && r_victim),
        .wvalid (w_fill_valid),
        .wtag   (r_sdram_addr),
        .wdata  (sdram_din),
        .lookup (w_tag),
        .hit    (w_hit_line[1]),
        .data   (w_data1)
    );

    assign w_hit  = rom_cs && (|w_hit_line);
    assign w_byte = byte_sel(w_hit_line[0] ? w_data0 : w_data1, cpu_addr[1:0]);

    // Lookup result is registered; rom_ok is qualified combinationally so it drops with cs/address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ok   <= 1'b0;
            r_addr <= '0;
            r_dout <= '0;
        end else begin
            r_ok   <= w_hit && !flush;
            r_addr <= cpu_addr;
            if (w_hit)
                r_dout <= w_byte;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_IDLE;
            r_req          <= 1'b0;
            r_sdram_addr   <= '0;
            r_victim       <= 1'b0;
            r_fill_flushed <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rom_cs && !(|w_hit_line)) begin
                        r_sdram_addr <= w_tag;
                        r_req        <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A flush seen while waiting makes the eventual fill land invalid.
                    if (flush)
                        r_fill_flushed <= 1'b1;
                    if (data_rdy) begin
                        r_fill_flushed <= 1'b0;
                        r_victim       <= ~r_victim;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rom_ok     = r_ok && rom_cs && (cpu_addr == r_addr);
    assign rom_dout   = r_dout;
    assign sdram_addr = r_sdram_addr;
    assign sdram_req  = r_req;
    assign dbg_state  = r_state;

endmodule
